// File: rtl/usrt_pkg.sv
// Shared constants for the USRT transmit controller: register map, bit
// positions, FSM encoding and reset defaults.
package usrt_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_BAUD   = 4'h8;
  localparam logic [3:0] ADDR_CTRL   = 4'hC;

  localparam int CTRL_TXEN  = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_FLUSH = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_CNT_LSB = 4;

  localparam logic [7:0] RST_BAUD_DEF = 8'd16;
  localparam int         DRAIN_W      = 12;

  typedef enum logic [2:0] {
    S_DRAIN = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_GAP   = 3'd5
  } tx_state_e;

  // Last count value of the post-reset drain window: the window lasts
  // 10*baud+2 cycles, counting from 0.
  function automatic logic [DRAIN_W-1:0] drain_last(input logic [7:0] baud);
    return ({4'b0, baud} * 12'd10) + 12'd1;
  endfunction

endpackage

// File: rtl/usrt_fifo.sv
// Synchronous FIFO with occupancy count and flush. Push when full and pop
// when empty are ignored; flush wins over a same-cycle push.
module usrt_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Push,
  input  logic [WIDTH-1:0] i_Data,
  input  logic             i_Pop,
  input  logic             i_Flush,
  output logic [WIDTH-1:0] o_Data,
  output logic [CW-1:0]    o_Count,
  output logic             o_Full,
  output logic             o_Empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign o_Full  = (r_count == CW'(DEPTH));
  assign o_Empty = (r_count == '0);
  assign o_Count = r_count;
  assign o_Data  = r_mem[r_rptr];
  assign w_push  = i_Push && !o_Full;
  assign w_pop   = i_Pop && !o_Empty;

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge i_Clk) begin
    if (w_push) r_mem[r_wptr] <= i_Data;
  end

  // Pointers and count; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_Flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/usrt_tx_ctrl.sv
// USRT transmit controller: APB register file, Tx FIFO and the frame
// sequencer that hands one byte at a time to the Tx shift register.
module usrt_tx_ctrl
  import usrt_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] RST_BAUD   = RST_BAUD_DEF
) (
  input  logic       i_Pclk,
  input  logic       i_Rst,
  input  logic       i_Psel,
  input  logic       i_Penable,
  input  logic       i_Pwrite,
  input  logic [3:0] i_Paddr,
  input  logic [7:0] i_Pwdata,
  output logic [7:0] o_Prdata,
  output logic       o_Pready,
  output logic       o_Pslverr,
  output logic       o_Tx_Enable,
  output logic [7:0] o_Tx_Data,
  output logic [7:0] o_Baud,
  input  logic       i_Tx_Done,
  output logic       o_Irq
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  tx_state_e          r_state, w_next;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [7:0]         r_baud, r_tx_data;
  logic               r_txen, r_irqen;

  logic               w_acc, w_busy, w_err, w_push, w_pop, w_flush;
  logic               w_baud_we, w_ctrl_we, w_avail, w_tx_en;
  logic [7:0]         w_rdata, w_status, w_fifo_data;
  logic [CW-1:0]      w_count;
  logic [2:0]         w_cnt3;
  logic               w_full, w_empty;

  assign w_acc  = i_Psel && i_Penable;
  assign w_busy = (r_state != S_IDLE);
  assign w_cnt3 = 3'(w_count);

  always_comb begin
    w_status               = '0;
    w_status[STAT_BUSY]    = w_busy;
    w_status[STAT_FULL]    = w_full;
    w_status[STAT_EMPTY]   = w_empty;
    w_status[STAT_CNT_LSB+:3] = w_cnt3;
  end

  usrt_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .i_Clk   (i_Pclk),
    .i_Rst   (i_Rst),
    .i_Push  (w_push),
    .i_Data  (i_Pwdata),
    .i_Pop   (w_pop),
    .i_Flush (w_flush),
    .o_Data  (w_fifo_data),
    .o_Count (w_count),
    .o_Full  (w_full),
    .o_Empty (w_empty)
  );

  // APB decode: read mux, error detection and per-register write strobes.
  always_comb begin
    w_rdata   = '0;
    w_err     = 1'b0;
    w_push    = 1'b0;
    w_flush   = 1'b0;
    w_baud_we = 1'b0;
    w_ctrl_we = 1'b0;
    if (w_acc) begin
      case (i_Paddr)
        ADDR_DATA: begin
          if (i_Pwrite) begin
            if (w_full) w_err  = 1'b1;
            else        w_push = 1'b1;
          end
        end
        ADDR_STATUS: begin
          if (i_Pwrite) w_err   = 1'b1;
          else          w_rdata = w_status;
        end
        ADDR_BAUD: begin
          if (i_Pwrite) begin
            // Baud must stay stable while a frame or the drain window is live.
            if (i_Pwdata == 8'd0 || w_busy) w_err     = 1'b1;
            else                            w_baud_we = 1'b1;
          end else begin
            w_rdata = r_baud;
          end
        end
        ADDR_CTRL: begin
          if (i_Pwrite) begin
            w_ctrl_we = 1'b1;
            w_flush   = i_Pwdata[CTRL_FLUSH];
          end else begin
            w_rdata[CTRL_TXEN]  = r_txen;
            w_rdata[CTRL_IRQEN] = r_irqen;
          end
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  assign o_Prdata  = w_rdata;
  assign o_Pslverr = w_err;
  assign o_Pready  = 1'b1;

  // BAUD and CTRL registers.
  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      r_baud  <= RST_BAUD;
      r_txen  <= 1'b0;
      r_irqen <= 1'b0;
    end else begin
      if (w_baud_we) r_baud <= i_Pwdata;
      if (w_ctrl_we) begin
        r_txen  <= i_Pwdata[CTRL_TXEN];
        r_irqen <= i_Pwdata[CTRL_IRQEN];
      end
    end
  end

  // Look ahead at this cycle's push so a write into an idle, empty FIFO
  // reaches LOAD on the very next cycle; a same-cycle flush cancels it.
  assign w_avail = (!w_empty || w_push) && !w_flush;

  // Sequencer state, drain counter and the latched frame byte.
  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state     <= S_DRAIN;
      r_drain_cnt <= '0;
      r_tx_data   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
      if (r_state == S_LOAD)  r_tx_data   <= w_fifo_data;
    end
  end

  // Next-state logic plus the pop strobe and the one-cycle shifter start.
  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_tx_en = 1'b0;
    case (r_state)
      S_DRAIN: if (r_drain_cnt == drain_last(r_baud)) w_next = S_IDLE;
      S_IDLE:  if (r_txen && w_avail) w_next = S_LOAD;
      S_LOAD: begin
        w_pop  = 1'b1;
        w_next = S_START;
      end
      S_START: begin
        w_tx_en = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT:  if (i_Tx_Done) w_next = S_GAP;
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_DRAIN;
    endcase
  end

  assign o_Tx_Enable = w_tx_en;
  assign o_Tx_Data   = r_tx_data;
  assign o_Baud      = r_baud;
  assign o_Irq       = r_irqen && w_empty && (r_state == S_IDLE);

endmodule
